// File: rtl/decoder_issue_arbiter.sv
// decoder_issue_arbiter
// Shares one non-pipelined instruction decoder between two requesters.
// Round-robin grant in IDLE, then a fixed handshake sequence:
//   IDLE -> ISSUE -> WAIT_RESULT -> RELEASE -> RETURN -> IDLE
// Only one instruction is ever in flight.
// Optional feature (macro DECODER_ISSUE_ARBITER_TIMEOUT_EN): a watchdog on
// WAIT_RESULT. If it expires, the arbiter returns an all-ones result and sets
// a sticky timeout_err flag. Without the macro, timeout_err is tied low and
// WAIT_RESULT waits indefinitely.

module decoder_issue_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_dir,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    output logic [1:0]            req_ack,
    output logic [1:0]            rsp_dor,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic [1:0]            rsp_ack,
    output logic                  dec_dir,
    output logic [DATA_WIDTH-1:0] dec_data,
    input  logic                  dec_ack_prev,
    input  logic                  dec_dor,
    input  logic [DATA_WIDTH-1:0] dec_data_out,
    output logic                  dec_ack_next,
    output logic                  owner,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_WAIT_RESULT = 3'd2,
        ST_RELEASE     = 3'd3,
        ST_RETURN      = 3'd4
    } state_e;

    // A zero-length watchdog or a zero-width datapath is meaningless.
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("decoder_issue_arbiter: TIMEOUT must be at least 1");
    end
    if (DATA_WIDTH == 0) begin : g_bad_width
        $error("decoder_issue_arbiter: DATA_WIDTH must be at least 1");
    end

    // Round-robin pick. A single request always wins. On a tie, the
    // requester that was not served last wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last);
        logic win;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
        return win;
    endfunction

    // Convert a requester index into its one-hot bit.
    function automatic logic [1:0] to_onehot(input logic idx);
        logic [1:0] oh;
        if (idx) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  dec_dir_q, dec_dir_d;
    logic [DATA_WIDTH-1:0] dec_data_q, dec_data_d;
    logic [1:0]            req_ack_q, req_ack_d;
    logic                  dec_ack_next_q, dec_ack_next_d;
    logic [1:0]            rsp_dor_q, rsp_dor_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  busy_q, busy_d;
    logic                  winner_s;

`ifdef DECODER_ISSUE_ARBITER_TIMEOUT_EN
    localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             timeout_err_q, timeout_err_d;
`endif

    // Next-state and next-output logic for the issue/return sequence.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        dec_dir_d      = dec_dir_q;
        dec_data_d     = dec_data_q;
        req_ack_d      = 2'b00;
        dec_ack_next_d = 1'b0;
        rsp_dor_d      = rsp_dor_q;
        rsp_data_d     = rsp_data_q;
        winner_s       = pick_winner(req_dir, last_grant_q);
`ifdef DECODER_ISSUE_ARBITER_TIMEOUT_EN
        cnt_d          = cnt_q;
        cnt_inc_s      = cnt_q + CNT_ONE;
        timeout_err_d  = timeout_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_dir != 2'b00) begin
                    owner_d   = winner_s;
                    dec_dir_d = 1'b1;
                    state_d   = ST_ISSUE;
                    if (winner_s) begin
                        dec_data_d = req_data1;
                    end else begin
                        dec_data_d = req_data0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                if (dec_ack_prev) begin
                    dec_dir_d    = 1'b0;
                    req_ack_d    = to_onehot(owner_q);
                    last_grant_d = owner_q;
                    state_d      = ST_WAIT_RESULT;
`ifdef DECODER_ISSUE_ARBITER_TIMEOUT_EN
                    cnt_d        = {CNT_W{1'b0}};
`endif
                end else begin
                    dec_dir_d = 1'b1;
                end
            end

            ST_WAIT_RESULT: begin
                if (dec_dor) begin
                    rsp_data_d     = dec_data_out;
                    dec_ack_next_d = 1'b1;
                    state_d        = ST_RELEASE;
                end
`ifdef DECODER_ISSUE_ARBITER_TIMEOUT_EN
                else if (cnt_inc_s == CNT_MAX) begin
                    // The decoder never answered: hand back an all-ones
                    // result so the requester is not left hung. No
                    // dec_ack_next is sent because there is no DOR to drop.
                    cnt_d         = cnt_inc_s;
                    timeout_err_d = 1'b1;
                    rsp_data_d    = {DATA_WIDTH{1'b1}};
                    state_d       = ST_RELEASE;
                end else begin
                    cnt_d = cnt_inc_s;
                end
`else
                else begin
                    state_d = ST_WAIT_RESULT;
                end
`endif
            end

            ST_RELEASE: begin
                rsp_dor_d = to_onehot(owner_q);
                state_d   = ST_RETURN;
            end

            ST_RETURN: begin
                if (rsp_ack[owner_q]) begin
                    rsp_dor_d = 2'b00;
                    state_d   = ST_IDLE;
                end else begin
                    rsp_dor_d = to_onehot(owner_q);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                dec_dir_d = 1'b0;
                rsp_dor_d = 2'b00;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. The asynchronous reset clears everything;
    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            dec_dir_q      <= 1'b0;
            dec_data_q     <= {DATA_WIDTH{1'b0}};
            req_ack_q      <= 2'b00;
            dec_ack_next_q <= 1'b0;
            rsp_dor_q      <= 2'b00;
            rsp_data_q     <= {DATA_WIDTH{1'b0}};
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            dec_dir_q      <= dec_dir_d;
            dec_data_q     <= dec_data_d;
            req_ack_q      <= req_ack_d;
            dec_ack_next_q <= dec_ack_next_d;
            rsp_dor_q      <= rsp_dor_d;
            rsp_data_q     <= rsp_data_d;
            busy_q         <= busy_d;
        end
    end

`ifdef DECODER_ISSUE_ARBITER_TIMEOUT_EN
    // Watchdog counter and sticky error flag. Only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= {CNT_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_ack      = req_ack_q;
    assign rsp_dor      = rsp_dor_q;
    assign rsp_data     = rsp_data_q;
    assign dec_dir      = dec_dir_q;
    assign dec_data     = dec_data_q;
    assign dec_ack_next = dec_ack_next_q;
    assign owner        = owner_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_decoder_issue_arbiter.sv
// Self-checking bench for decoder_issue_arbiter.
// It contains a behavioural decoder, a table of directed transactions,
// hand-written corner sequences, and randomized transactions. The randomized
// transactions are predicted by a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_decoder_issue_arbiter;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic [1:0]    req_dir;
    logic [DW-1:0] req_data0, req_data1;
    logic [1:0]    req_ack;
    logic [1:0]    rsp_dor;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_ack;
    logic          dec_dir;
    logic [DW-1:0] dec_data;
    logic          dec_ack_prev;
    logic          dec_dor;
    logic [DW-1:0] dec_data_out;
    logic          dec_ack_next;
    logic          owner;
    logic          busy;
    logic          timeout_err;

    int n_chk = 0;
    int n_fail = 0;
    int ack_next_cnt = 0;
    int ack_base = 0;
    logic mdl_last = 1'b1;

    int m_ack_lat = 1;
    int m_dor_lat = 3;
    bit m_dor_never = 1'b0;

    decoder_issue_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_dir(req_dir), .req_data0(req_data0), .req_data1(req_data1),
        .req_ack(req_ack), .rsp_dor(rsp_dor), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
        .dec_dir(dec_dir), .dec_data(dec_data), .dec_ack_prev(dec_ack_prev),
        .dec_dor(dec_dor), .dec_data_out(dec_data_out), .dec_ack_next(dec_ack_next),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Result produced by the behavioural decoder for a given instruction.
    function automatic logic [31:0] model_result(input logic [31:0] ins);
        if (ins == 32'h01095020) return 32'h0000000A;
        else return ~ins;
    endfunction

    // Behavioural decoder. It acks after m_ack_lat cycles and keeps ack_prev
    // high for two cycles. It raises DOR m_dor_lat cycles later and drops DOR
    // when it sees ack_from_next.
    initial begin
        int ms;
        int mc;
        logic [31:0] mdata;
        ms = 0; mc = 0; mdata = 32'h0;
        dec_ack_prev = 1'b0; dec_dor = 1'b0; dec_data_out = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ms = 0; mc = 0;
                dec_ack_prev = 1'b0; dec_dor = 1'b0;
            end else begin
                case (ms)
                    0: if (dec_dir) begin
                           mc++;
                           if (mc >= m_ack_lat) begin
                               dec_ack_prev = 1'b1; mdata = dec_data; mc = 0; ms = 1;
                           end
                       end else mc = 0;
                    1: begin
                           mc++;
                           if (mc >= 2) begin dec_ack_prev = 1'b0; mc = 0; ms = 2; end
                       end
                    2: begin
                           mc++;
                           if (!m_dor_never && mc >= m_dor_lat) begin
                               dec_dor = 1'b1; dec_data_out = model_result(mdata); ms = 3;
                           end
                       end
                    3: if (dec_ack_next) begin dec_dor = 1'b0; mc = 0; ms = 0; end
                    default: ms = 0;
                endcase
            end
        end
    end

    // Count dec_ack_next high cycles.
    initial forever begin
        @(negedge clk);
        if (dec_ack_next === 1'b1) ack_next_cnt++;
    end

    // Hard time limit.
    initial begin
        #300000;
        $display("FAIL global_time_limit: run did not complete, required completion before 300000ns");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Wait, at negedges, for a condition: 0 dec_dir, 1 req_ack, 2 rsp_dor.
    task automatic wait_cond(input int sel, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            case (sel)
                0: hit = (dec_dir === 1'b1);
                1: hit = (req_ack !== 2'b00);
                2: hit = (rsp_dor !== 2'b00);
                default: hit = 1'b1;
            endcase
            if (!hit) @(negedge clk);
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: got no event in 200 cycles, expected event", name);
        end
    endtask

    task automatic issue_phase(input logic [1:0] rq, input logic [31:0] d0, input logic [31:0] d1,
                               input logic eo, input logic [31:0] edec);
        logic [1:0] oh;
        oh = eo ? 2'b10 : 2'b01;
        req_dir = rq; req_data0 = d0; req_data1 = d1;
        ack_base = ack_next_cnt;
        wait_cond(0, "dec_dir_rise");
        chk("owner", 32'(owner), 32'(eo));
        chk("dec_data", dec_data, edec);
        chk("busy_issue", 32'(busy), 32'd1);
        wait_cond(1, "req_ack_pulse");
        chk("req_ack", 32'(req_ack), 32'(oh));
        mdl_last = eo;
        req_dir = req_dir & ~oh;
        @(negedge clk);
        chk("req_ack_one_cycle", 32'(req_ack), 32'd0);
        chk("dec_dir_drop", 32'(dec_dir), 32'd0);
    endtask

    task automatic result_phase(input logic eo, input logic [31:0] ersp, input int pulses);
        wait_cond(2, "rsp_dor_rise");
        chk("rsp_dor", 32'(rsp_dor), eo ? 32'd2 : 32'd1);
        chk("rsp_data", rsp_data, ersp);
        chk("ack_next_pulses", 32'(ack_next_cnt - ack_base), 32'(pulses));
    endtask

    task automatic finish_phase(input logic eo, input int delay, input logic [31:0] ersp);
        logic [1:0] oh;
        oh = eo ? 2'b10 : 2'b01;
        for (int i = 0; i < delay; i++) @(negedge clk);
        chk("rsp_dor_held", 32'(rsp_dor), 32'(oh));
        chk("rsp_data_held", rsp_data, ersp);
        rsp_ack = oh;
        @(negedge clk);
        rsp_ack = 2'b00;
        req_dir = 2'b00;
        chk("rsp_dor_clear", 32'(rsp_dor), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  rq;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        eo;
        logic [31:0] edec;
        logic [31:0] ersp;
    } vec_t;

    vec_t tv [11];
    logic [1:0]  r_rq;
    logic [31:0] r_d0, r_d1, r_win;
    logic        r_eo;
    int          dir_seen;
    int          n_to;

    initial begin
        tv[0]  = '{2'b11, 32'h0000000A, 32'h0000000B, 1'b0, 32'h0000000A, 32'hFFFFFFF5};
        tv[1]  = '{2'b11, 32'h0000000A, 32'h0000000B, 1'b1, 32'h0000000B, 32'hFFFFFFF4};
        tv[2]  = '{2'b11, 32'h0000000A, 32'h0000000B, 1'b0, 32'h0000000A, 32'hFFFFFFF5};
        tv[3]  = '{2'b11, 32'h0000000A, 32'h0000000B, 1'b1, 32'h0000000B, 32'hFFFFFFF4};
        tv[4]  = '{2'b01, 32'h01095020, 32'h0000000B, 1'b0, 32'h01095020, 32'h0000000A};
        tv[5]  = '{2'b10, 32'h0000000C, 32'h12345678, 1'b1, 32'h12345678, 32'hEDCBA987};
        tv[6]  = '{2'b11, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'hFFFFFFFF};
        tv[7]  = '{2'b01, 32'h00000005, 32'h00000006, 1'b0, 32'h00000005, 32'hFFFFFFFA};
        tv[8]  = '{2'b11, 32'h00000007, 32'h00000008, 1'b1, 32'h00000008, 32'hFFFFFFF7};
        tv[9]  = '{2'b10, 32'h00000009, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h21524110};
        tv[10] = '{2'b11, 32'h00000001, 32'h00000002, 1'b0, 32'h00000001, 32'hFFFFFFFE};

        reset = 1'b0; req_dir = 2'b00; req_data0 = 32'h0; req_data1 = 32'h0; rsp_ack = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({req_ack, rsp_dor, dec_dir, dec_ack_next, owner, busy, timeout_err}), 32'd0);
        chk("reset_dec_data", dec_data, 32'h0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        reset = 1'b1;

        // Directed table, starting with ties straight after reset.
        for (int k = 0; k < 11; k++) begin
            issue_phase(tv[k].rq, tv[k].d0, tv[k].d1, tv[k].eo, tv[k].edec);
            result_phase(tv[k].eo, tv[k].ersp, 1);
            finish_phase(tv[k].eo, k % 2, tv[k].ersp);
        end

        // Late response ack: a pending request must wait for rsp_ack[1].
        issue_phase(2'b10, 32'h0, 32'h55, 1'b1, 32'h55);
        result_phase(1'b1, ~32'h55, 1);
        req_dir = 2'b01; req_data0 = 32'h66;
        dir_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dec_dir === 1'b1) dir_seen++;
        end
        chk("late_ack_no_issue", 32'(dir_seen), 32'd0);
        finish_phase(1'b1, 0, ~32'h55);
        issue_phase(2'b11, 32'h66, 32'h67, 1'b0, 32'h66);
        result_phase(1'b0, ~32'h66, 1);

        // Wrong-owner ack is ignored.
        rsp_ack = 2'b10;
        repeat (3) @(negedge clk);
        chk("wrong_ack_rsp_dor", 32'(rsp_dor), 32'd1);
        chk("wrong_ack_busy", 32'(busy), 32'd1);
        chk("wrong_ack_owner", 32'(owner), 32'd0);
        rsp_ack = 2'b00;
        finish_phase(1'b0, 0, ~32'h66);

        // Asynchronous reset in WAIT_RESULT.
        m_dor_lat = 30;
        issue_phase(2'b01, 32'h77, 32'h0, 1'b0, 32'h77);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_ctrl", 32'({req_ack, rsp_dor, dec_dir, dec_ack_next, owner, busy, timeout_err}), 32'd0);
        chk("async_reset_dec_data", dec_data, 32'h0);
        chk("async_reset_rsp_data", rsp_data, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1; m_dor_lat = 3; mdl_last = 1'b1;
        issue_phase(2'b11, 32'h31, 32'h32, 1'b0, 32'h31);
        result_phase(1'b0, ~32'h31, 1);
        finish_phase(1'b0, 0, ~32'h31);

        // Randomized transactions against the round-robin model.
        for (int t = 0; t < 30; t++) begin
            r_rq = 2'($urandom_range(3, 1));
            r_d0 = $urandom; r_d1 = $urandom;
            m_ack_lat = $urandom_range(3, 1);
            m_dor_lat = $urandom_range(4, 1);
            if (r_rq == 2'b01) r_eo = 1'b0;
            else if (r_rq == 2'b10) r_eo = 1'b1;
            else r_eo = ~mdl_last;
            r_win = r_eo ? r_d1 : r_d0;
            issue_phase(r_rq, r_d0, r_d1, r_eo, r_win);
            result_phase(r_eo, model_result(r_win), 1);
            finish_phase(r_eo, $urandom_range(3, 0), model_result(r_win));
        end

`ifdef DECODER_ISSUE_ARBITER_TIMEOUT_EN
        // Decoder accepts but never raises DOR.
        m_ack_lat = 1; m_dor_never = 1'b1;
        issue_phase(2'b01, 32'h99, 32'h0, 1'b0, 32'h99);
        n_to = 0;
        while (timeout_err !== 1'b1 && n_to < 50) begin
            @(negedge clk);
            n_to++;
        end
        chk("timeout_latency", 32'(n_to), 32'd7);
        result_phase(1'b0, 32'hFFFFFFFF, 0);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        finish_phase(1'b0, 0, 32'hFFFFFFFF);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
`else
        n_to = 0;
        chk("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_issue_arbiter.md
Name: decoder_issue_arbiter

Overview:
- Shares the single, non-pipelined instruction_decoder between two instruction sources, for example a fetch unit and a debug/injection port.
- Arbitrates round-robin and forwards the winning instruction over the DIR/ack_prev handshake.
- Collects the decoder's DOR/data_out result, acknowledges it, and returns the result to the requester that issued it.
- Exactly one instruction is in flight at a time.

Parameters:
- DATA_WIDTH, 32, width of instruction and result words.
- TIMEOUT, 64, cycles allowed for the decoder to raise DOR after accepting; used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_dir  in  2  per-requester "instruction ready"; level, held until req_ack.
- req_data0  in  DATA_WIDTH  instruction from requester 0.
- req_data1  in  DATA_WIDTH  instruction from requester 1.
- req_ack  out  2  one-cycle pulse to the granted requester when the decoder accepts its instruction.
- rsp_dor  out  2  result-ready flag, one-hot on the owner bit.
- rsp_data  out  DATA_WIDTH  result word, valid while any rsp_dor bit is high.
- rsp_ack  in  2  requester consumes the result.
- dec_dir  out  1  drives the decoder DIR input.
- dec_data  out  DATA_WIDTH  drives the decoder data_in.
- dec_ack_prev  in  1  decoder ack_prev output.
- dec_dor  in  1  decoder DOR output.
- dec_data_out  in  DATA_WIDTH  decoder data_out.
- dec_ack_next  out  1  drives the decoder ack_from_next input.
- owner  out  1  index of the current grant; valid when busy=1.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky error flag; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; last_grant=1 so requester 0 wins the first tie; result register cleared.
- Reset takes effect mid-transaction from any state. The system resets the decoder from the same source.
- All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req_dir bit set: grant that requester.
  - Both bits set: grant !last_grant.
  - On grant: latch the selected req_data into dec_data; set owner; dec_dir<=1; go to ISSUE.
- ISSUE:
  - Hold dec_dir=1 and dec_data stable.
  - When dec_ack_prev=1: dec_dir<=0; req_ack[owner]<=1 for exactly one cycle; last_grant<=owner; go to WAIT_RESULT.
- WAIT_RESULT:
  - When dec_dor=1: latch dec_data_out into rsp_data; dec_ack_next<=1; go to RELEASE.
- RELEASE:
  - dec_ack_next is high for exactly this one cycle; it is deasserted on exit. The decoder samples it and drops DOR.
  - rsp_dor[owner]<=1; go to RETURN.
- RETURN:
  - Hold rsp_dor[owner] and rsp_data.
  - When rsp_ack[owner]=1: rsp_dor<=0; go to IDLE.
  - rsp_ack on the non-owner bit is ignored.
- Arbitration is evaluated only in IDLE. req_dir changes in other states have no effect.
- A requester that drops req_dir before its grant simply loses its turn; no state is kept for it.
- Minimum turnaround (decoder answering immediately, requester acking immediately) is IDLE→ISSUE→WAIT_RESULT→RELEASE→RETURN→IDLE. Back-to-back grants are therefore at least 5 cycles apart, plus decoder latency.
- dec_ack_prev staying high after ISSUE (the decoder holds it until WAITING_ACK) is ignored outside ISSUE.
- Both req_dir bits high continuously gives a strict 0,1,0,1 alternation.

Optional Feature:
- Macro: DECODER_ISSUE_ARBITER_TIMEOUT_EN.
- When defined:
  - A counter, clog2(TIMEOUT+1) bits wide, is cleared on entry to WAIT_RESULT and increments each cycle in WAIT_RESULT.
  - When it reaches TIMEOUT with dec_dor still 0: timeout_err<=1 (sticky until reset); rsp_data<=all ones; go to RELEASE without asserting dec_ack_next. The requester is not left hung.
  - A dec_dor arriving in the same cycle that the count reaches TIMEOUT takes priority, and no error is raised.
- When undefined: no counter; timeout_err is constant 0; WAIT_RESULT waits indefinitely.

Test Plan:
- Single request: req_dir=01, req_data0=0x01095020 (add $t2,$t0,$t1); decoder model acks after 1 cycle and returns 0x0000000A after 3 cycles → req_ack=01 pulse, one dec_ack_next pulse, rsp_dor=01, rsp_data=0x0000000A until rsp_ack[0].
- Tie after reset: req_dir=11 held, 4 transactions with distinct data 0xA/0xB → owner sequence 0,1,0,1; dec_data alternates req_data0/req_data1.
- Late response ack: requester 1 holds rsp_ack=0 for 10 cycles while req_dir[0]=1 → no new dec_dir until rsp_ack[1]; requester 0 granted next.
- Wrong-owner ack: owner=0 in RETURN, rsp_ack=10 → rsp_dor stays 01; state unchanged.
- Reset mid-operation: assert reset=0 during WAIT_RESULT → all outputs 0 asynchronously; after release, first tie goes to requester 0.
- Timeout (macro defined, TIMEOUT=8): decoder acks but never raises DOR → timeout_err=1 after 8 cycles in WAIT_RESULT; rsp_data=0xFFFFFFFF; rsp_dor[owner]=1; dec_ack_next stays 0.
